// File: rtl/lampFPU_pkg.sv
// Shared lampFPU definitions: format widths, canonical special encodings,
// controller state and operand-class enums, and the operand classifier.
package lampFPU_pkg;

   localparam int E_DW   = 8;
   localparam int F_DW   = 7;
   localparam int E_BIAS = 127;
   localparam int OP_W   = 1 + E_DW + F_DW;
   localparam int EXP_W  = E_DW + 2;
   localparam int FRAC_W = F_DW + 2;

   localparam logic [OP_W-1:0] QNAN = 16'h7FC0;
   localparam logic [OP_W-1:0] PINF = 16'h7F80;
   localparam logic [OP_W-1:0] NINF = 16'hFF80;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_NORM = 2'd2
   } sqrt_state_t;

   typedef enum logic [1:0] {
      CLS_ZERO = 2'd0,
      CLS_NORM = 2'd1,
      CLS_INF  = 2'd2,
      CLS_NAN  = 2'd3
   } op_class_t;

   // Subnormals (e = 0) are flushed and classified as zero.
   function automatic op_class_t classify(input logic [OP_W-1:0] op);
      logic [E_DW-1:0] e;
      logic [F_DW-1:0] m;
      e = op[F_DW +: E_DW];
      m = op[F_DW-1:0];
      if (e == {E_DW{1'b1}}) begin
         return (m != {F_DW{1'b0}}) ? CLS_NAN : CLS_INF;
      end else if (e == {E_DW{1'b0}}) begin
         return CLS_ZERO;
      end else begin
         return CLS_NORM;
      end
   endfunction

endpackage

// File: rtl/lampfpu_sqrt_norm_round.sv
// Normalizes the Q2.14 core result, rounds it and packs the final float.
// Rounding mode: LAMPFPU_SQRT_RNE_EN selects round-to-nearest-even, else truncation.
module lampfpu_sqrt_norm_round
   import lampFPU_pkg::*;
(
   input  logic [15:0]             frac_res,
   input  logic signed [EXP_W-1:0] half_exp,
   input  logic                    inv,
   output logic [OP_W-1:0]         res,
   output logic                    invalid
);

   logic [F_DW-1:0]         mant_s;
   logic [7:0]              tail_s;
   logic signed [EXP_W-1:0] adj_s;
   logic signed [EXP_W-1:0] exp_s;
   logic                    found_s;
   logic                    round_up_s;
   logic [F_DW:0]           mant_rnd_s;

   // Leading-one detect over the integer/top fraction bits; tail holds guard then sticky bits.
   always_comb begin
      mant_s  = {F_DW{1'b0}};
      tail_s  = 8'h00;
      adj_s   = 10'sd0;
      found_s = 1'b1;
      casez (frac_res[15:13])
         3'b1??: begin
            mant_s = frac_res[14:8];
            tail_s = frac_res[7:0];
            adj_s  = 10'sd1;
         end
         3'b01?: begin
            mant_s = frac_res[13:7];
            tail_s = {frac_res[6:0], 1'b0};
            adj_s  = 10'sd0;
         end
         3'b001: begin
            mant_s = frac_res[12:6];
            tail_s = {frac_res[5:0], 2'b00};
            adj_s  = -10'sd1;
         end
         default: begin
            found_s = 1'b0;
         end
      endcase
   end

`ifdef LAMPFPU_SQRT_RNE_EN
   assign round_up_s = tail_s[7] & ((|tail_s[6:0]) | mant_s[0]);
`else
   logic unused_tail;
   assign round_up_s  = 1'b0;
   assign unused_tail = ^tail_s;
`endif

   assign mant_rnd_s = {1'b0, mant_s} + {{F_DW{1'b0}}, round_up_s};

   // Exponent assembly with rounding carry, overflow/underflow saturation and packing.
   always_comb begin
      exp_s = (inv ? -half_exp : half_exp) + adj_s + EXP_W'(E_BIAS)
              + {{(EXP_W-1){1'b0}}, mant_rnd_s[F_DW]};
      invalid = 1'b0;
      if (!found_s) begin
         res     = QNAN;
         invalid = 1'b1;
      end else if (exp_s >= 10'sd255) begin
         res = PINF;
      end else if (exp_s <= 10'sd0) begin
         res = {OP_W{1'b0}};
      end else begin
         res = {1'b0, exp_s[E_DW-1:0], mant_rnd_s[F_DW-1:0]};
      end
   end

endmodule

// File: rtl/lampfpu_sqrt_ctrl.sv
// Operation controller for the lampFPU sqrt / inverse-sqrt unit: resolves special
// operands, drives the fractional core and finishes its result (see LAMPFPU_SQRT_RNE_EN).
module lampfpu_sqrt_ctrl
   import lampFPU_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              doSqrt_i,
   input  logic              doInvSqrt_i,
   input  logic [OP_W-1:0]   op_i,
   output logic              ready_o,
   output logic [OP_W-1:0]   res_o,
   output logic              valid_o,
   output logic              invalid_o,
   output logic              divZero_o,
   output logic              frac_doSqrt_o,
   output logic              frac_doInvSqrt_o,
   output logic [FRAC_W-1:0] frac_f_o,
   input  logic [15:0]       frac_res_i,
   input  logic              frac_valid_i
);

   sqrt_state_t             state_r, state_nxt;
   logic                    ready_r, ready_nxt;
   logic                    valid_r, valid_nxt;
   logic [OP_W-1:0]         res_r, res_nxt;
   logic                    invalid_r, invalid_nxt;
   logic                    divzero_r, divzero_nxt;
   logic                    pulse_sqrt_r, pulse_sqrt_nxt;
   logic                    pulse_inv_r, pulse_inv_nxt;
   logic [FRAC_W-1:0]       frac_f_r, frac_f_nxt;
   logic signed [EXP_W-1:0] half_exp_r, half_exp_nxt;
   logic                    inv_r, inv_nxt;
   logic [15:0]             core_res_r, core_res_nxt;

   logic                    accept_s;
   logic                    inv_req_s;
   logic                    sign_s;
   op_class_t               cls_s;
   logic                    special_s;
   logic [OP_W-1:0]         sp_res_s;
   logic                    sp_invalid_s;
   logic                    sp_divzero_s;
   logic signed [EXP_W-1:0] unb_s;
   logic                    odd_s;
   logic [FRAC_W-1:0]       prep_frac_s;
   logic signed [EXP_W-1:0] prep_half_s;
   logic [OP_W-1:0]         norm_res_s;
   logic                    norm_invalid_s;

   // ready_r also gates the cycle right after NORM, where the state is already IDLE.
   assign accept_s  = (state_r == S_IDLE) && ready_r && (doSqrt_i || doInvSqrt_i);
   assign inv_req_s = doInvSqrt_i & ~doSqrt_i;
   assign sign_s    = op_i[OP_W-1];
   assign cls_s     = classify(op_i);

   // Special-operand resolution; special_s drops only for positive normal operands.
   always_comb begin
      special_s    = 1'b1;
      sp_res_s     = {OP_W{1'b0}};
      sp_invalid_s = 1'b0;
      sp_divzero_s = 1'b0;
      case (cls_s)
         CLS_NAN: begin
            sp_res_s = QNAN;
         end
         CLS_ZERO: begin
            if (inv_req_s) begin
               sp_res_s     = sign_s ? NINF : PINF;
               sp_divzero_s = 1'b1;
            end else begin
               sp_res_s = {sign_s, {(OP_W-1){1'b0}}};
            end
         end
         CLS_INF: begin
            if (sign_s) begin
               sp_res_s     = QNAN;
               sp_invalid_s = 1'b1;
            end else if (inv_req_s) begin
               sp_res_s = {OP_W{1'b0}};
            end else begin
               sp_res_s = PINF;
            end
         end
         CLS_NORM: begin
            if (sign_s) begin
               sp_res_s     = QNAN;
               sp_invalid_s = 1'b1;
            end else begin
               special_s = 1'b0;
            end
         end
         default: begin
            sp_res_s = QNAN;
         end
      endcase
   end

   // Odd unbiased exponent: operand 1.m/2 and E+1; even: 1.m/4 and E+2, so E' is always even.
   assign unb_s       = $signed({2'b00, op_i[F_DW +: E_DW]}) - EXP_W'(E_BIAS);
   assign odd_s       = unb_s[0];
   assign prep_frac_s = odd_s ? {1'b1, op_i[F_DW-1:0], 1'b0} : {2'b01, op_i[F_DW-1:0]};
   assign prep_half_s = (unb_s + (odd_s ? 10'sd1 : 10'sd2)) >>> 1;

   lampfpu_sqrt_norm_round u_norm_round (
      .frac_res (core_res_r),
      .half_exp (half_exp_r),
      .inv      (inv_r),
      .res      (norm_res_s),
      .invalid  (norm_invalid_s)
   );

   // Next-state and next-output logic.
   always_comb begin
      state_nxt      = state_r;
      valid_nxt      = 1'b0;
      res_nxt        = {OP_W{1'b0}};
      invalid_nxt    = 1'b0;
      divzero_nxt    = 1'b0;
      pulse_sqrt_nxt = 1'b0;
      pulse_inv_nxt  = 1'b0;
      frac_f_nxt     = frac_f_r;
      half_exp_nxt   = half_exp_r;
      inv_nxt        = inv_r;
      core_res_nxt   = core_res_r;
      case (state_r)
         S_IDLE: begin
            if (accept_s && special_s) begin
               valid_nxt   = 1'b1;
               res_nxt     = sp_res_s;
               invalid_nxt = sp_invalid_s;
               divzero_nxt = sp_divzero_s;
            end else if (accept_s) begin
               state_nxt      = S_WAIT;
               frac_f_nxt     = prep_frac_s;
               half_exp_nxt   = prep_half_s;
               inv_nxt        = inv_req_s;
               pulse_sqrt_nxt = ~inv_req_s;
               pulse_inv_nxt  = inv_req_s;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         S_WAIT: begin
            if (frac_valid_i) begin
               state_nxt    = S_NORM;
               core_res_nxt = frac_res_i;
            end else begin
               state_nxt = S_WAIT;
            end
         end
         S_NORM: begin
            state_nxt   = S_IDLE;
            valid_nxt   = 1'b1;
            res_nxt     = norm_res_s;
            invalid_nxt = norm_invalid_s;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
      ready_nxt = (state_nxt == S_IDLE) && (state_r != S_NORM);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= S_IDLE;
         ready_r      <= 1'b1;
         valid_r      <= 1'b0;
         res_r        <= {OP_W{1'b0}};
         invalid_r    <= 1'b0;
         divzero_r    <= 1'b0;
         pulse_sqrt_r <= 1'b0;
         pulse_inv_r  <= 1'b0;
         frac_f_r     <= {FRAC_W{1'b0}};
         half_exp_r   <= 10'sd0;
         inv_r        <= 1'b0;
         core_res_r   <= 16'h0000;
      end else begin
         state_r      <= state_nxt;
         ready_r      <= ready_nxt;
         valid_r      <= valid_nxt;
         res_r        <= res_nxt;
         invalid_r    <= invalid_nxt;
         divzero_r    <= divzero_nxt;
         pulse_sqrt_r <= pulse_sqrt_nxt;
         pulse_inv_r  <= pulse_inv_nxt;
         frac_f_r     <= frac_f_nxt;
         half_exp_r   <= half_exp_nxt;
         inv_r        <= inv_nxt;
         core_res_r   <= core_res_nxt;
      end
   end

   assign ready_o          = ready_r;
   assign valid_o          = valid_r;
   assign res_o            = res_r;
   assign invalid_o        = invalid_r;
   assign divZero_o        = divzero_r;
   assign frac_doSqrt_o    = pulse_sqrt_r;
   assign frac_doInvSqrt_o = pulse_inv_r;
   assign frac_f_o         = frac_f_r;

endmodule

// File: tb/tb_lampfpu_sqrt_ctrl.sv
// Self-checking bench for lampfpu_sqrt_ctrl: the bench plays the fractional core,
// predicts results with a float-level model and checks every cycle.
module tb_lampfpu_sqrt_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        doSqrt_i, doInvSqrt_i;
   logic [15:0] op_i;
   logic        ready_o, valid_o, invalid_o, divZero_o;
   logic [15:0] res_o;
   logic        frac_doSqrt_o, frac_doInvSqrt_o;
   logic [8:0]  frac_f_o;
   logic [15:0] frac_res_i;
   logic        frac_valid_i;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit chk_en = 1'b0;

   logic [17:0] exp_valid [int];   // {invalid, divzero, res} keyed by cycle
   logic [1:0]  exp_pulse [int];   // {sqrt, invsqrt} keyed by cycle

   lampfpu_sqrt_ctrl dut (
      .clk              (clk),
      .rst              (rst),
      .doSqrt_i         (doSqrt_i),
      .doInvSqrt_i      (doInvSqrt_i),
      .op_i             (op_i),
      .ready_o          (ready_o),
      .res_o            (res_o),
      .valid_o          (valid_o),
      .invalid_o        (invalid_o),
      .divZero_o        (divZero_o),
      .frac_doSqrt_o    (frac_doSqrt_o),
      .frac_doInvSqrt_o (frac_doInvSqrt_o),
      .frac_f_o         (frac_f_o),
      .frac_res_i       (frac_res_i),
      .frac_valid_i     (frac_valid_i)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Special-operand result: {special, invalid, divzero, res}
   function automatic logic [18:0] model_special(input logic [15:0] op, input logic inv);
      logic [7:0] e;
      logic [6:0] m;
      logic       s;
      e = op[14:7];
      m = op[6:0];
      s = op[15];
      if (e == 8'hFF && m != 7'd0) return {3'b100, 16'h7FC0};
      if (e == 8'h00) return inv ? {3'b101, (s ? 16'hFF80 : 16'h7F80)} : {3'b100, s, 15'd0};
      if (s) return {3'b110, 16'h7FC0};
      if (e == 8'hFF) return inv ? {3'b100, 16'h0000} : {3'b100, 16'h7F80};
      return 19'd0;
   endfunction

   function automatic logic [8:0] model_frac(input logic [15:0] op);
      int ue;
      ue = int'(op[14:7]) - 127;
      if (ue % 2 != 0) return {1'b1, op[6:0], 1'b0};
      return {2'b01, op[6:0]};
   endfunction

   function automatic int model_half(input logic [15:0] op);
      int ue;
      ue = int'(op[14:7]) - 127;
      return (ue % 2 != 0) ? (ue + 1) / 2 : (ue + 2) / 2;
   endfunction

   // Final float from the Q2.14 core value r and E'/2: {invalid, divzero, res}
   function automatic logic [17:0] model_norm(input logic [15:0] r, input int half, input logic inv);
      int p, sh, mant, ex;
      p = -1;
      for (int b = 13; b <= 15; b++) if (r[b]) p = b;
      if (p < 0) return {2'b10, 16'h7FC0};
      sh   = p - 7;
      mant = (int'(r) >> sh) & 127;
      ex   = (inv ? -half : half) + (p - 14) + 127;
`ifdef LAMPFPU_SQRT_RNE_EN
      begin
         int  rem;
         bit  g, st;
         rem = int'(r) & ((1 << sh) - 1);
         g   = ((rem >> (sh - 1)) & 1) != 0;
         st  = (rem & ((1 << (sh - 1)) - 1)) != 0;
         if (g && (st || (mant % 2 == 1))) mant++;
      end
`endif
      if (mant == 128) begin
         mant = 0;
         ex++;
      end
      if (ex >= 255) return {2'b00, 16'h7F80};
      if (ex <= 0) return 18'd0;
      return {2'b00, 1'b0, ex[7:0], mant[6:0]};
   endfunction

   // Per-cycle comparison of strobes and results against the scheduled expectations.
   always @(negedge clk) begin
      if (chk_en) begin
         if (exp_valid.exists(cyc)) begin
            check("valid", 32'(valid_o), 32'd1);
            check("res", 32'(res_o), 32'(exp_valid[cyc][15:0]));
            check("invalid", 32'(invalid_o), 32'(exp_valid[cyc][17]));
            check("divzero", 32'(divZero_o), 32'(exp_valid[cyc][16]));
            exp_valid.delete(cyc);
         end else begin
            check("valid_idle", 32'(valid_o), 32'd0);
            check("res_idle", 32'(res_o), 32'd0);
         end
         if (exp_pulse.exists(cyc)) begin
            check("core_pulse", 32'({frac_doSqrt_o, frac_doInvSqrt_o}), 32'(exp_pulse[cyc]));
            exp_pulse.delete(cyc);
         end else begin
            check("core_pulse_idle", 32'({frac_doSqrt_o, frac_doInvSqrt_o}), 32'd0);
         end
      end
   end

   task automatic run_op(input logic [15:0] op, input logic sq, input logic iv,
                         input logic [15:0] core_r, input int lat, input bit lit_en,
                         input logic [17:0] lit, input logic [8:0] lit_f, input bit poke);
      int          c, t;
      logic        inv_eff;
      logic [18:0] sp;
      logic [8:0]  ef;
      @(posedge clk); #1;
      c           = cyc;
      doSqrt_i    = sq;
      doInvSqrt_i = iv;
      op_i        = op;
      inv_eff     = iv & ~sq;
      sp          = model_special(op, inv_eff);
      ef          = lit_en ? lit_f : model_frac(op);
      if (sp[18]) exp_valid[c+1] = lit_en ? lit : sp[17:0];
      else        exp_pulse[c+1] = inv_eff ? 2'b01 : 2'b10;
      @(posedge clk); #1;
      doSqrt_i    = 1'b0;
      doInvSqrt_i = 1'b0;
      op_i        = 16'($urandom);
      if (sp[18]) begin
         check("ready_after_special", 32'(ready_o), 32'd1);
      end else begin
         check("frac_f", 32'(frac_f_o), 32'(ef));
         check("ready_busy", 32'(ready_o), 32'd0);
         if (poke) begin
            doSqrt_i = 1'b1;
            op_i     = 16'h0000;
         end
         for (int i = 0; i < lat; i++) begin
            @(posedge clk); #1;
            doSqrt_i = 1'b0;
            check("frac_f_hold", 32'(frac_f_o), 32'(ef));
            check("ready_wait", 32'(ready_o), 32'd0);
         end
         t            = cyc;
         frac_res_i   = core_r;
         frac_valid_i = 1'b1;
         exp_valid[t+2] = lit_en ? lit : model_norm(core_r, model_half(op), inv_eff);
         @(posedge clk); #1;
         doSqrt_i     = 1'b0;
         frac_valid_i = poke;
         frac_res_i   = poke ? 16'hFFFF : 16'($urandom);
         check("ready_norm", 32'(ready_o), 32'd0);
         @(posedge clk); #1;
         frac_valid_i = 1'b0;
         check("ready_valid_cycle", 32'(ready_o), 32'd0);
         if (poke) begin
            doSqrt_i = 1'b1;
            op_i     = 16'h0000;
         end
         @(posedge clk); #1;
         doSqrt_i = 1'b0;
         check("ready_return", 32'(ready_o), 32'd1);
      end
   endtask

   initial begin
      int          c;
      logic [15:0] op;
      logic [1:0]  rq;
      int          k;
      rst          = 1'b1;
      doSqrt_i     = 1'b0;
      doInvSqrt_i  = 1'b0;
      op_i         = 16'h0000;
      frac_res_i   = 16'h0000;
      frac_valid_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", 32'(ready_o), 32'd1);
      check("rst_valid", 32'(valid_o), 32'd0);
      check("rst_res", 32'(res_o), 32'd0);
      check("rst_flags", 32'({invalid_o, divZero_o}), 32'd0);
      check("rst_pulse", 32'({frac_doSqrt_o, frac_doInvSqrt_o}), 32'd0);
      check("rst_frac_f", 32'(frac_f_o), 32'd0);
      rst    = 1'b0;
      chk_en = 1'b1;

      run_op(16'h4080, 1'b1, 1'b0, 16'h2000, 2, 1'b1, {2'b00, 16'h4000}, 9'h080, 1'b0);
      run_op(16'h4080, 1'b0, 1'b1, 16'h8000, 1, 1'b1, {2'b00, 16'h3F00}, 9'h080, 1'b0);
      run_op(16'h4000, 1'b1, 1'b0, 16'h2D41, 3, 1'b1, {2'b00, 16'h3FB5}, 9'h100, 1'b1);
`ifdef LAMPFPU_SQRT_RNE_EN
      run_op(16'h4000, 1'b1, 1'b0, 16'h2FFF, 0, 1'b1, {2'b00, 16'h3FC0}, 9'h100, 1'b0);
`else
      run_op(16'h4000, 1'b1, 1'b0, 16'h2FFF, 0, 1'b1, {2'b00, 16'h3FBF}, 9'h100, 1'b0);
`endif
      run_op(16'hBF80, 1'b1, 1'b0, 16'h0000, 0, 1'b1, {2'b10, 16'h7FC0}, 9'h000, 1'b0);
      run_op(16'h0000, 1'b0, 1'b1, 16'h0000, 0, 1'b1, {2'b01, 16'h7F80}, 9'h000, 1'b0);
      run_op(16'h7F80, 1'b1, 1'b0, 16'h0000, 0, 1'b1, {2'b00, 16'h7F80}, 9'h000, 1'b0);
      run_op(16'h4080, 1'b1, 1'b1, 16'h2000, 0, 1'b1, {2'b00, 16'h4000}, 9'h080, 1'b0);
      run_op(16'h4080, 1'b1, 1'b0, 16'h1FFF, 1, 1'b1, {2'b10, 16'h7FC0}, 9'h080, 1'b0);

      // Reset while waiting on the core, then a stale core response.
      @(posedge clk); #1;
      c           = cyc;
      doSqrt_i    = 1'b1;
      op_i        = 16'h4080;
      exp_pulse[c+1] = 2'b10;
      @(posedge clk); #1;
      doSqrt_i = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_ready", 32'(ready_o), 32'd1);
      check("abort_outputs", 32'({valid_o, invalid_o, divZero_o, frac_doSqrt_o, frac_doInvSqrt_o}), 32'd0);
      check("abort_res", 32'(res_o), 32'd0);
      check("abort_frac_f", 32'(frac_f_o), 32'd0);
      frac_valid_i = 1'b1;
      frac_res_i   = 16'h2000;
      @(posedge clk); #1;
      frac_valid_i = 1'b0;
      check("abort_ready_after", 32'(ready_o), 32'd1);
      repeat (3) @(posedge clk);

      for (int n = 0; n < 80; n++) begin
         k  = int'($urandom_range(0, 9));
         rq = 2'($urandom_range(1, 3));
         case (k)
            0:       op = {1'($urandom), 8'hFF, 7'($urandom_range(1, 127))};
            1:       op = {1'($urandom), 8'hFF, 7'd0};
            2:       op = {1'($urandom), 8'h00, 7'($urandom)};
            3:       op = {1'b1, 8'($urandom_range(1, 254)), 7'($urandom)};
            default: op = {1'b0, 8'($urandom_range(1, 254)), 7'($urandom)};
         endcase
         run_op(op, rq[1], rq[0], 16'($urandom), int'($urandom_range(0, 4)),
                1'b0, 18'd0, 9'd0, bit'($urandom_range(0, 1)));
      end

      repeat (4) @(posedge clk);
      #1;
      check("pending_valid", 32'(exp_valid.num()), 32'd0);
      check("pending_pulse", 32'(exp_pulse.num()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
